fp32_pcpi_bridge: RTL and testbench
===================================

# fp32_pcpi_bridge

Initiator-side bridge between the picorv32 PCPI co-processor port and the FP32 multiplier's strobe/busy handshake. It decodes the custom FMUL instruction, issues rs1/rs2 to the multiplier, and consumes the result strobe. It returns the product to the core through `pcpi_rd`. It sits between the core and the multiplier, and both blocks share clk and rst.

## Interface
- `OPCODE`, default 7'b0001011: custom-0 major opcode matched on `pcpi_insn[6:0]`.
- `FUNCT7`, default 7'b0000100: matched on `pcpi_insn[31:25]`. `pcpi_insn[14:12]` must be 3'b000.
- `TIMEOUT`, default 64: maximum cycles spent in ISSUE+WAIT_RES before the bridge aborts.
- `clk` in 1: clock.
- `rst` in 1: reset. Synchronous, active-high.
- `pcpi_valid` in 1: core presents an instruction.
- `pcpi_insn` in 32: instruction word.
- `pcpi_rs1`, `pcpi_rs2` in 32: FP32 operands a and b.
- `pcpi_wr` out 1: write `pcpi_rd` to rd. Valid only with `pcpi_ready`.
- `pcpi_rd` out 32: result.
- `pcpi_wait` out 1: bridge owns the instruction and is not yet done.
- `pcpi_ready` out 1: one-cycle completion pulse.
- `op_a`, `op_b` out 32: operands to the multiplier.
- `op_stb` out 1: operands valid.
- `op_busy` in 1: multiplier busy. Transfer occurs on `op_stb && !op_busy`.
- `res` in 32: multiplier result.
- `res_stb` in 1: result valid.
- `res_busy` out 1: bridge not accepting. Transfer occurs on `res_stb && !res_busy`.
- `err` out 1: sticky timeout flag. Cleared only by rst.

## Operation
- Decode: `hit = pcpi_valid && insn[6:0]==OPCODE && insn[31:25]==FUNCT7 && insn[14:12]==0`. The bridge ignores non-hits: it never asserts wait, ready or `op_stb` for them.
- FSM states are IDLE, ISSUE, WAIT_RES, RESP and DRAIN.
- IDLE: on `hit`, latch rs1 into `op_a` and rs2 into `op_b`, clear the timeout counter, set `pcpi_wait`=1 and `op_stb`=1, then go to ISSUE.
- ISSUE: hold `op_stb` and the operands stable. When `op_stb && !op_busy`, drop `op_stb` and go to WAIT_RES.
- WAIT_RES: `res_busy`=0. When `res_stb && !res_busy`, capture `res` into `pcpi_rd`, set `res_busy`=1, and go to RESP.
- RESP: `pcpi_ready`=1 and `pcpi_wr`=1 for exactly one cycle. `pcpi_wait`=0. Next state is IDLE.
- Timeout: the counter increments every cycle in ISSUE or WAIT_RES. If it reaches `TIMEOUT`-1 without a transfer:
  - `pcpi_rd`=32'h7FC00000 (canonical NaN), `err`=1, go to RESP;
  - `op_stb` is forced to 0.
- `pcpi_valid` deasserts while in ISSUE or WAIT_RES (core abort): drop `pcpi_wait`.
  - If the operands were already transferred, go to DRAIN. DRAIN holds `res_busy`=0, discards the next accepted result without `pcpi_ready`, then returns to IDLE.
  - If the operands were not transferred, go straight to IDLE.
- `res_busy`=1 in every state except WAIT_RES and DRAIN.
- A result accepted in the same cycle the timeout fires has priority over the timeout: it returns the real result and `err` is unchanged.

## Timing
- Reset values:
  - all outputs are 0, except `res_busy`=1;
  - `op_a`, `op_b` and `pcpi_rd` are 32'h0;
  - state is IDLE, counter is 0, `err`=0.
- `pcpi_wait` is registered and rises the cycle after the `hit` cycle. This is within picorv32's 16-cycle wait window.
- `op_stb` rises the cycle after `hit`. The earliest issue transfer is that same cycle.
- Bridge overhead: 1 cycle before the issue transfer, then 1 cycle from the result transfer to `pcpi_ready`.
- `pcpi_ready` is never asserted in consecutive cycles. A new `hit` is only decoded in IDLE, so back-to-back instructions have at least one IDLE cycle between them.
- rst mid-operation returns the bridge to IDLE the next cycle. The multiplier resets on the same rst, so no drain is needed.

## Structure
- Shared package `fp32_pkg` holds:
  - `FMUL_OPCODE`, `FMUL_FUNCT7`, `FMUL_FUNCT3`;
  - `FP32_QNAN` = 32'h7FC00000;
  - the bridge state enum.
- No sub-module. An optional `fp32_insn_decode` combinational helper is allowed, to be shared later by adder/divider bridges.

## Test plan
- rs1=32'h40000000, rs2=32'h40400000, FMUL insn, real multiplier → `pcpi_ready` pulse with `pcpi_wr`=1 and `pcpi_rd`=32'h40C00000; `pcpi_wait` high from the cycle after `hit` until ready.
- rs1=32'h3FC00000, rs2=32'hC0000000 → `pcpi_rd`=32'hC0400000. A second FMUL issued immediately after returns a correct, independent result.
- insn with funct7=7'b0000001 → `pcpi_wait`, `pcpi_ready` and `op_stb` stay 0 for 100 cycles.
- Stub multiplier with `op_busy` stuck at 1, `TIMEOUT`=64 → `pcpi_ready` 64 cycles after `op_stb` rises, `pcpi_rd`=32'h7FC00000, `err`=1 until rst.
- Stub holds `res_stb` low for 20 cycles while `op_busy` toggles, then pulses it → operands stable throughout ISSUE, result captured in one cycle, `res_busy` low only in WAIT_RES.
- Drop `pcpi_valid` after the issue transfer → no `pcpi_ready`, result drained via DRAIN. Separately, assert rst in WAIT_RES → the next cycle shows all reset values and a fresh FMUL completes correctly.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared FP32 co-processor definitions: custom-0 FMUL encoding, canonical NaN,
// bridge state encoding and the instruction decode helper reused by sibling bridges.
package fp32_pkg;

  localparam logic [6:0]  FMUL_OPCODE = 7'b0001011;
  localparam logic [6:0]  FMUL_FUNCT7 = 7'b0000100;
  localparam logic [2:0]  FMUL_FUNCT3 = 3'b000;
  localparam logic [31:0] FP32_QNAN   = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RES,
    ST_RESP,
    ST_DRAIN
  } bridge_state_t;

  function automatic logic fp32_insn_decode(input logic        valid,
                                            input logic [31:0] insn,
                                            input logic [6:0]  opcode,
                                            input logic [6:0]  funct7);
    return valid && (insn[6:0] == opcode) && (insn[31:25] == funct7) &&
           (insn[14:12] == FMUL_FUNCT3);
  endfunction

endpackage

// File: rtl/fp32_pcpi_bridge.sv
// picorv32 PCPI to FP32 multiplier bridge: decodes FMUL, issues operands over
// the strobe/busy handshake and returns the product (or qNaN on timeout).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for an FMUL hit; res_busy high
// ISSUE     | op_stb high, operands held until the multiplier takes them
// WAIT_RES  | res_busy low, waiting for the result strobe
// RESP      | one-cycle pcpi_ready/pcpi_wr pulse
// DRAIN     | core aborted after issue; swallow the orphaned result
module fp32_pcpi_bridge
  import fp32_pkg::*;
#(
  parameter logic [6:0] OPCODE  = FMUL_OPCODE,
  parameter logic [6:0] FUNCT7  = FMUL_FUNCT7,
  parameter int         TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        op_stb,
  input  logic        op_busy,
  input  logic [31:0] res,
  input  logic        res_stb,
  output logic        res_busy,
  output logic        err
);

  // One extra bit so the counter can step past TIMEOUT-1 when the operand
  // transfer lands on the final ISSUE cycle; the >= compare still fires.
  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  bridge_state_t state;
  logic [CW-1:0] cnt;
  logic          hit;
  logic          op_xfer;
  logic          res_xfer;
  logic          tmo;

  assign hit      = fp32_insn_decode(pcpi_valid, pcpi_insn, OPCODE, FUNCT7);
  assign op_xfer  = op_stb && !op_busy;
  assign res_xfer = res_stb && !res_busy;
  assign tmo      = (cnt >= CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_stb     <= 1'b0;
      res_busy   <= 1'b1;
      err        <= 1'b0;
    end else begin
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hit) begin
            op_a      <= pcpi_rs1;
            op_b      <= pcpi_rs2;
            cnt       <= '0;
            pcpi_wait <= 1'b1;
            op_stb    <= 1'b1;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!pcpi_valid) begin
            pcpi_wait <= 1'b0;
            op_stb    <= 1'b0;
            res_busy  <= !op_xfer;
            state     <= op_xfer ? ST_DRAIN : ST_IDLE;
          end else if (op_xfer) begin
            op_stb   <= 1'b0;
            res_busy <= 1'b0;
            cnt      <= cnt + 1'b1;
            state    <= ST_WAIT_RES;
          end else if (tmo) begin
            op_stb     <= 1'b0;
            pcpi_rd    <= FP32_QNAN;
            err        <= 1'b1;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_RES: begin
          if (!pcpi_valid) begin
            // A result arriving with the abort is simply consumed.
            pcpi_wait <= 1'b0;
            res_busy  <= res_xfer;
            state     <= res_xfer ? ST_IDLE : ST_DRAIN;
          end else if (res_xfer) begin
            pcpi_rd    <= res;
            res_busy   <= 1'b1;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            state      <= ST_RESP;
          end else if (tmo) begin
            pcpi_rd    <= FP32_QNAN;
            err        <= 1'b1;
            res_busy   <= 1'b1;
            pcpi_wait  <= 1'b0;
            pcpi_ready <= 1'b1;
            pcpi_wr    <= 1'b1;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (res_xfer) begin
            res_busy <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state    <= ST_IDLE;
          res_busy <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_pcpi_bridge.sv
// Bench for fp32_pcpi_bridge: core-side stimulus, a behavioural multiplier stub
// and a high-level FP32 product reference.
module tb_fp32_pcpi_bridge;

  localparam logic [6:0]  OPC  = 7'b0001011;
  localparam logic [6:0]  F7   = 7'b0000100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk;
  logic        rst;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_stb;
  logic        op_busy;
  logic [31:0] res;
  logic        res_stb;
  logic        res_busy;
  logic        err;

  int checks   = 0;
  int failures = 0;

  fp32_pcpi_bridge #(.OPCODE(OPC), .FUNCT7(F7), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .op_a(op_a), .op_b(op_b), .op_stb(op_stb), .op_busy(op_busy),
    .res(res), .res_stb(res_stb), .res_busy(res_busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference FP32 product for normal operands without overflow (truncating).
  function automatic logic [31:0] fp32_mul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [22:0] frac;
    int          e;
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e++;
      frac = p[46:24];
    end else begin
      frac = p[45:23];
    end
    return {a[31] ^ b[31], 8'(e), frac};
  endfunction

  function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [6:0] opc);
    return {f7, 5'($urandom), 5'($urandom), f3, 5'($urandom), opc};
  endfunction

  function automatic logic [31:0] rnd_fp32();
    return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
  endfunction

  // Multiplier stub: busy_mode 0=never busy, 1=stuck busy, 2=random, 3=toggle.
  int          busy_mode  = 0;
  int          res_delay  = 0;
  int          stub_taken = 0;
  int          stub_dly   = 0;
  logic        stub_pending;
  logic [31:0] stub_a, stub_b;

  always @(posedge clk) begin
    if (rst) begin
      op_busy      <= 1'b0;
      res_stb      <= 1'b0;
      res          <= '0;
      stub_pending <= 1'b0;
    end else begin
      case (busy_mode)
        0:       op_busy <= 1'b0;
        1:       op_busy <= 1'b1;
        2:       op_busy <= 1'($urandom_range(0, 1));
        default: op_busy <= !op_busy;
      endcase
      if (res_stb) begin
        if (!res_busy) begin
          res_stb      <= 1'b0;
          stub_pending <= 1'b0;
          stub_taken   <= stub_taken + 1;
        end
      end else if (stub_pending) begin
        if (stub_dly == 0) begin
          res_stb <= 1'b1;
          res     <= fp32_mul(stub_a, stub_b);
        end else begin
          stub_dly <= stub_dly - 1;
        end
      end else if (op_stb && !op_busy) begin
        stub_pending <= 1'b1;
        stub_dly     <= res_delay;
        stub_a       <= op_a;
        stub_b       <= op_b;
      end
    end
  end

  // Protocol monitors running for the whole simulation.
  logic prev_ready = 1'b0;
  int   consec_ready = 0;
  int   ready_wr_bad = 0;
  always @(negedge clk) begin
    if (pcpi_ready && prev_ready) consec_ready++;
    if (pcpi_ready !== pcpi_wr) ready_wr_bad++;
    prev_ready = pcpi_ready;
  end

  // Observations from the last run_fmul call.
  int          r_ready_at, r_stb_at, r_wait_gaps, r_opnd_bad;
  int          r_rbusy_low, r_rbusy_bad, r_rstb_hi;
  logic [31:0] r_rd;
  logic        r_wr;

  task automatic run_fmul(input logic [31:0] insn, input logic [31:0] a,
                          input logic [31:0] b, input int budget);
    r_ready_at = -1; r_stb_at = -1; r_wait_gaps = 0; r_opnd_bad = 0;
    r_rbusy_low = 0; r_rbusy_bad = 0; r_rstb_hi = 0; r_rd = '0; r_wr = 1'b0;
    @(negedge clk);
    pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_valid = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (op_stb && r_stb_at < 0) r_stb_at = i;
      if (op_stb && (op_a !== a || op_b !== b)) r_opnd_bad++;
      if (!res_busy) begin
        r_rbusy_low++;
        if (!pcpi_wait) r_rbusy_bad++;
      end
      if (res_stb) r_rstb_hi++;
      if (pcpi_ready) begin
        r_ready_at = i; r_rd = pcpi_rd; r_wr = pcpi_wr;
        if (pcpi_wait) r_wait_gaps++;
        break;
      end
      if (!pcpi_wait) r_wait_gaps++;
    end
    pcpi_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pcpi_wait, pcpi_ready, pcpi_wr, op_stb, err} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: wait/ready/wr/stb/err=%b required 00000",
               {pcpi_wait, pcpi_ready, pcpi_wr, op_stb, err});
    end
    checks++;
    if (res_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_res_busy: got %b required 1", res_busy);
    end
    checks++;
    if ({op_a, op_b, pcpi_rd} !== 96'h0) begin
      failures++;
      $display("FAIL reset_data: op_a=%h op_b=%h rd=%h required all 0", op_a, op_b, pcpi_rd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    busy_mode = 0; res_delay = 0;
    run_fmul(mk_insn(F7, 3'b000, OPC), 32'h4000_0000, 32'h4040_0000, 40);
    checks++;
    if (r_rd !== 32'h40C0_0000 || r_wr !== 1'b1) begin
      failures++;
      $display("FAIL basic_2x3: rd=%h wr=%b required 40c00000 wr=1", r_rd, r_wr);
    end
    checks++;
    if (r_stb_at != 1 || r_ready_at != 4) begin
      failures++;
      $display("FAIL basic_latency: stb_at=%0d ready_at=%0d required 1 and 4", r_stb_at, r_ready_at);
    end
    checks++;
    if (r_wait_gaps != 0) begin
      failures++;
      $display("FAIL basic_wait: wait gaps=%0d required 0", r_wait_gaps);
    end
  endtask

  task automatic test_back_to_back();
    busy_mode = 0; res_delay = 0;
    run_fmul(mk_insn(F7, 3'b000, OPC), 32'h3FC0_0000, 32'hC000_0000, 40);
    checks++;
    if (r_rd !== 32'hC040_0000 || r_ready_at < 0) begin
      failures++;
      $display("FAIL b2b_first: rd=%h ready_at=%0d required c0400000", r_rd, r_ready_at);
    end
    run_fmul(mk_insn(F7, 3'b000, OPC), 32'h4080_0000, 32'h4100_0000, 40);
    checks++;
    if (r_rd !== 32'h4200_0000 || r_ready_at < 0) begin
      failures++;
      $display("FAIL b2b_second: rd=%h ready_at=%0d required 42000000", r_rd, r_ready_at);
    end
  endtask

  task automatic test_nonhit();
    logic [31:0] bad [3];
    int          len [3];
    int          viol;
    bad[0] = mk_insn(7'b0000001, 3'b000, OPC); len[0] = 100;
    bad[1] = mk_insn(F7, 3'b000, 7'b0110011);  len[1] = 20;
    bad[2] = mk_insn(F7, 3'b010, OPC);         len[2] = 20;
    for (int k = 0; k < 3; k++) begin
      viol = 0;
      @(negedge clk);
      pcpi_insn = bad[k]; pcpi_rs1 = rnd_fp32(); pcpi_rs2 = rnd_fp32(); pcpi_valid = 1'b1;
      for (int i = 0; i < len[k]; i++) begin
        @(negedge clk);
        if (pcpi_wait || pcpi_ready || op_stb) viol++;
      end
      pcpi_valid = 1'b0;
      checks++;
      if (viol != 0) begin
        failures++;
        $display("FAIL nonhit_%0d: %0d cycles with wait/ready/stb, required 0", k, viol);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp_rd;
    busy_mode = 2;
    for (int n = 0; n < 30; n++) begin
      a = rnd_fp32(); b = rnd_fp32(); exp_rd = fp32_mul(a, b);
      res_delay = $urandom_range(0, 8);
      run_fmul(mk_insn(F7, 3'b000, OPC), a, b, 80);
      checks++;
      if (r_ready_at < 0 || r_rd !== exp_rd || r_wait_gaps != 0 || r_opnd_bad != 0) begin
        failures++;
        $display("FAIL random_%0d: a=%h b=%h rd=%h required %h ready_at=%0d gaps=%0d opnd_bad=%0d",
                 n, a, b, r_rd, exp_rd, r_ready_at, r_wait_gaps, r_opnd_bad);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL random_err: err=%b required 0", err);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] a, b;
    busy_mode = 1;
    run_fmul(mk_insn(F7, 3'b000, OPC), 32'h4000_0000, 32'h4000_0000, 100);
    checks++;
    if (r_stb_at != 1 || r_ready_at - r_stb_at != 64) begin
      failures++;
      $display("FAIL timeout_latency: stb_at=%0d ready_at=%0d required ready 64 after stb",
               r_stb_at, r_ready_at);
    end
    checks++;
    if (r_rd !== QNAN || err !== 1'b1 || op_stb !== 1'b0) begin
      failures++;
      $display("FAIL timeout_result: rd=%h err=%b op_stb=%b required 7fc00000 1 0", r_rd, err, op_stb);
    end
    busy_mode = 0; res_delay = 2;
    a = rnd_fp32(); b = rnd_fp32();
    run_fmul(mk_insn(F7, 3'b000, OPC), a, b, 40);
    checks++;
    if (r_rd !== fp32_mul(a, b) || err !== 1'b1) begin
      failures++;
      $display("FAIL timeout_sticky: rd=%h err=%b required %h err=1", r_rd, err, fp32_mul(a, b));
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear: err=%b after rst required 0", err);
    end
  endtask

  task automatic test_slow_result();
    logic [31:0] a, b;
    busy_mode = 3; res_delay = 20;
    a = rnd_fp32(); b = rnd_fp32();
    run_fmul(mk_insn(F7, 3'b000, OPC), a, b, 60);
    checks++;
    if (r_ready_at < 0 || r_rd !== fp32_mul(a, b) || r_opnd_bad != 0) begin
      failures++;
      $display("FAIL slow_result: rd=%h required %h ready_at=%0d opnd_bad=%0d",
               r_rd, fp32_mul(a, b), r_ready_at, r_opnd_bad);
    end
    checks++;
    if (r_rstb_hi != 1 || r_rbusy_low != res_delay + 2 || r_rbusy_bad != 0) begin
      failures++;
      $display("FAIL slow_handshake: res_stb cycles=%0d res_busy low=%0d (outside wait %0d) required 1 %0d 0",
               r_rstb_hi, r_rbusy_low, r_rbusy_bad, res_delay + 2);
    end
  endtask

  task automatic test_abort();
    int seen, readies, taken0, rbl;
    logic [31:0] a, b;
    busy_mode = 0; res_delay = 6;
    @(negedge clk);
    pcpi_insn = mk_insn(F7, 3'b000, OPC); pcpi_rs1 = rnd_fp32(); pcpi_rs2 = rnd_fp32();
    pcpi_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (!res_busy) seen = 1;
    end
    taken0 = stub_taken;
    pcpi_valid = 1'b0;
    readies = 0; rbl = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pcpi_ready || pcpi_wait) readies++;
      if (!res_busy) rbl++;
    end
    checks++;
    if (seen != 1 || readies != 0 || stub_taken != taken0 + 1 || rbl == 0) begin
      failures++;
      $display("FAIL abort_drain: reached_wait=%0d ready/wait cycles=%0d drained=%0d required 1 0 1",
               seen, readies, stub_taken - taken0);
    end
    busy_mode = 1;
    @(negedge clk);
    pcpi_insn = mk_insn(F7, 3'b000, OPC); pcpi_valid = 1'b1;
    repeat (3) @(negedge clk);
    taken0 = stub_taken;
    pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (pcpi_wait !== 1'b0 || op_stb !== 1'b0 || res_busy !== 1'b1 || stub_taken != taken0) begin
      failures++;
      $display("FAIL abort_issue: wait=%b stb=%b res_busy=%b required 0 0 1", pcpi_wait, op_stb, res_busy);
    end
    busy_mode = 0; res_delay = 1;
    a = rnd_fp32(); b = rnd_fp32();
    run_fmul(mk_insn(F7, 3'b000, OPC), a, b, 40);
    checks++;
    if (r_rd !== fp32_mul(a, b) || r_ready_at < 0) begin
      failures++;
      $display("FAIL abort_recover: rd=%h required %h ready_at=%0d", r_rd, fp32_mul(a, b), r_ready_at);
    end
  endtask

  task automatic test_rst_mid();
    int seen;
    logic [31:0] a, b;
    busy_mode = 0; res_delay = 10;
    @(negedge clk);
    pcpi_insn = mk_insn(F7, 3'b000, OPC); pcpi_rs1 = rnd_fp32(); pcpi_rs2 = rnd_fp32();
    pcpi_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (!res_busy) seen = 1;
    end
    rst = 1'b1; pcpi_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (seen != 1 || {pcpi_wait, pcpi_ready, pcpi_wr, op_stb, err} !== 5'b0 || res_busy !== 1'b1 ||
        {op_a, op_b, pcpi_rd} !== 96'h0) begin
      failures++;
      $display("FAIL rst_mid: reached_wait=%0d wait=%b ready=%b stb=%b res_busy=%b rd=%h required reset values",
               seen, pcpi_wait, pcpi_ready, op_stb, res_busy, pcpi_rd);
    end
    rst = 1'b0;
    res_delay = 3;
    a = rnd_fp32(); b = rnd_fp32();
    run_fmul(mk_insn(F7, 3'b000, OPC), a, b, 40);
    checks++;
    if (r_rd !== fp32_mul(a, b) || r_ready_at < 0) begin
      failures++;
      $display("FAIL rst_recover: rd=%h required %h ready_at=%0d", r_rd, fp32_mul(a, b), r_ready_at);
    end
  endtask

  initial begin
    rst = 1'b1; pcpi_valid = 1'b0; pcpi_insn = '0; pcpi_rs1 = '0; pcpi_rs2 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_nonhit();
    test_random();
    test_timeout();
    test_slow_result();
    test_abort();
    test_rst_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (consec_ready != 0 || ready_wr_bad != 0) begin
      failures++;
      $display("FAIL ready_protocol: consecutive ready=%0d ready/wr disagree=%0d required 0 0",
               consec_ready, ready_wr_bad);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
